// File: rtl/tea_pkg.sv
// Shared constants and FSM state type for the TEA CBC packer.
//   BLOCK_W         : cipher block width in bits
//   BYTES_PER_BLOCK : message bytes per block
//   CNT_W           : width of the byte counter (0..BYTES_PER_BLOCK-1)
//   state_e         : packer FSM states
package tea_pkg;

  localparam int unsigned BLOCK_W         = 64;
  localparam int unsigned BYTES_PER_BLOCK = 8;
  localparam int unsigned CNT_W           = 3;

  typedef enum logic [1:0] {
    StFill,
    StStart,
    StWait,
    StOut
  } state_e;

endpackage

// File: rtl/tea_byte_packer.sv
// Assembles message bytes MSB-first into a cipher block and applies the
// count-valued padding when a message ends short of a full block.
//   clk_i, rst_i : clock, synchronous active-high reset
//   ready_i      : bytes may be accepted (FSM in fill state)
//   valid_i      : byte offered
//   data_i       : message byte
//   last_i       : byte is the final one of the message
//   cnt_o        : bytes currently buffered
//   done_o       : the byte accepted this cycle completes a block
//   block_o      : assembled, padded block including the current byte
module tea_byte_packer
  import tea_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ready_i,
  input  logic               valid_i,
  input  logic [7:0]         data_i,
  input  logic               last_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               done_o,
  output logic [BLOCK_W-1:0] block_o
);

  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic [7:0]         pad_val;

  assign accept  = valid_i && ready_i;
  assign done_o  = accept && (last_i || (cnt_q == CNT_W'(BYTES_PER_BLOCK - 1)));
  assign cnt_o   = cnt_q;
  // With k = cnt_q + 1 bytes present, the remaining bytes carry the value 8 - k.
  assign pad_val = 8'(BYTES_PER_BLOCK - 1) - 8'(cnt_q);

  // Earlier bytes from the buffer, the current byte in slot cnt_q, padding after it.
  // When the block is full the padding slots are empty, so no pad is ever emitted.
  always_comb begin
    block_o = '0;
    for (int i = 0; i < int'(BYTES_PER_BLOCK); i++) begin
      if (i < int'(cnt_q)) begin
        block_o[int'(BLOCK_W) - 1 - 8 * i -: 8] = buf_q[int'(BLOCK_W) - 1 - 8 * i -: 8];
      end else if (i == int'(cnt_q)) begin
        block_o[int'(BLOCK_W) - 1 - 8 * i -: 8] = data_i;
      end else begin
        block_o[int'(BLOCK_W) - 1 - 8 * i -: 8] = pad_val;
      end
    end
  end

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (accept) begin
      // Pad bytes written here are overwritten by later bytes of the same block.
      buf_d = block_o;
      cnt_d = done_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tea_cbc_packer.sv
// Byte-stream front end for a TEA block core in CBC mode. Packs bytes into
// 64-bit blocks, XORs with the chain value, drives the core and presents the
// ciphertext downstream.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready/in_data : byte input handshake
//   in_last                   : final byte of a message
//   iv_load, iv               : IV strobe and value (honoured only when idle)
//   core_start                : one-cycle start pulse to the core
//   core_plaintext            : block to encrypt, held until core_done
//   core_done, core_ciphertext: core result (sticky done)
//   out_valid/out_ready       : ciphertext output handshake
//   out_data, out_last        : ciphertext block and end-of-message flag
//   busy                      : anything buffered or in flight
module tea_cbc_packer
  import tea_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  input  logic               iv_load,
  input  logic [BLOCK_W-1:0] iv,
  output logic               core_start,
  output logic [BLOCK_W-1:0] core_plaintext,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_ciphertext,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_last,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] chain_q, chain_d;
  logic [BLOCK_W-1:0] iv_q, iv_d;
  logic [BLOCK_W-1:0] pt_q, pt_d;
  logic [BLOCK_W-1:0] out_data_q, out_data_d;
  logic               last_q, last_d;
  logic               first_q, first_d;

  logic [CNT_W-1:0]   pk_cnt;
  logic               pk_done;
  logic [BLOCK_W-1:0] pk_block;

  logic               fill_empty;
  logic               iv_take;
  logic [BLOCK_W-1:0] chain_eff;

  tea_byte_packer u_packer (
    .clk_i   (clk),
    .rst_i   (rst),
    .ready_i (in_ready),
    .valid_i (in_valid),
    .data_i  (in_data),
    .last_i  (in_last),
    .cnt_o   (pk_cnt),
    .done_o  (pk_done),
    .block_o (pk_block)
  );

  assign fill_empty = (state_q == StFill) && (pk_cnt == '0);
  assign iv_take    = fill_empty && iv_load;
  // A same-cycle IV load applies before a one-byte message's block is formed.
  assign chain_eff  = iv_take ? iv : chain_q;

  assign in_ready       = (state_q == StFill);
  assign core_start     = (state_q == StStart);
  assign out_valid      = (state_q == StOut);
  assign core_plaintext = pt_q;
  assign out_data       = out_data_q;
  assign out_last       = last_q;
  assign busy           = !fill_empty;

  always_comb begin
    state_d    = state_q;
    chain_d    = chain_q;
    iv_d       = iv_q;
    pt_d       = pt_q;
    out_data_d = out_data_q;
    last_d     = last_q;
    first_d    = 1'b0;

    unique case (state_q)
      StFill: begin
        if (iv_take) begin
          iv_d    = iv;
          chain_d = iv;
        end
        if (pk_done) begin
          pt_d    = pk_block ^ chain_eff;
          last_d  = in_last;
          state_d = StStart;
        end
      end
      StStart: begin
        first_d = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        // core_done may still be high from the previous block in the first cycle.
        if (!first_q && core_done) begin
          out_data_d = core_ciphertext;
          chain_d    = core_ciphertext;
          state_d    = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          if (last_q) begin
            chain_d = iv_q;
          end
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFill;
      chain_q    <= '0;
      iv_q       <= '0;
      pt_q       <= '0;
      out_data_q <= '0;
      last_q     <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      chain_q    <= chain_d;
      iv_q       <= iv_d;
      pt_q       <= pt_d;
      out_data_q <= out_data_d;
      last_q     <= last_d;
      first_q    <= first_d;
    end
  end

endmodule

// File: tb/tb_tea_cbc_packer.sv
// Bench for tea_cbc_packer: behavioural TEA core with configurable latency and
// a message-level CBC reference model.
module tb_tea_cbc_packer;

  localparam int CORE_LAT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        iv_load = 1'b0;
  logic [63:0] iv = 64'h0;
  logic        core_start;
  logic [63:0] core_plaintext;
  logic        core_done;
  logic [63:0] core_ciphertext;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;

  int n_assert = 0;
  int n_fail = 0;
  int n_starts = 0;
  int exp_starts = 0;

  logic [63:0]  model_iv = 64'h0;
  logic [63:0]  first_pt;
  byte unsigned msg[$];
  logic [63:0]  exp_pt[$];
  logic [63:0]  exp_ct[$];
  logic         exp_last[$];

  tea_cbc_packer dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .iv_load        (iv_load),
    .iv             (iv),
    .core_start     (core_start),
    .core_plaintext (core_plaintext),
    .core_done      (core_done),
    .core_ciphertext(core_ciphertext),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] tea_enc(input logic [63:0] p);
    logic [31:0] v0, v1, sum;
    v0  = p[63:32];
    v1  = p[31:0];
    sum = 32'h0;
    for (int r = 0; r < 32; r++) begin
      sum = sum + 32'h9E3779B9;
      v0  = v0 + (((v1 << 4) + 32'hA56BABCD) ^ (v1 + sum) ^ ((v1 >> 5) + 32'h0000F00D));
      v1  = v1 + (((v0 << 4) + 32'h12345678) ^ (v0 + sum) ^ ((v0 >> 5) + 32'hDEADBEEF));
    end
    return {v0, v1};
  endfunction

  // Core model: accepts a start one edge late, so done stays stale for a cycle.
  logic start_seen = 1'b0;
  int   lat_cnt = 0;
  initial begin
    core_done       = 1'b0;
    core_ciphertext = 64'h0;
  end
  always @(posedge clk) begin
    if (rst) begin
      core_done       <= 1'b0;
      core_ciphertext <= 64'h0;
      start_seen      <= 1'b0;
      lat_cnt         <= 0;
    end else begin
      start_seen <= core_start;
      if (start_seen) begin
        core_done       <= 1'b0;
        core_ciphertext <= tea_enc(core_plaintext);
        lat_cnt         <= CORE_LAT - 1;
      end else if (lat_cnt > 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1) core_done <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (core_start) n_starts <= n_starts + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic summary_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  endtask

  // sel 0: in_ready, sel 1: out_valid
  task automatic wait_for(input int sel, input int limit, input string tag);
    int t = 0;
    while (((sel == 0) ? in_ready : out_valid) !== 1'b1 && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) begin
      check(tag, {63'h0, (sel == 0) ? in_ready : out_valid}, 64'h1);
      summary_and_finish();
    end
  endtask

  // CBC over the whole message: 8-byte chunks, final short chunk padded with its gap size.
  function automatic void build_model();
    logic [63:0] chain, blk;
    int n, idx, nb;
    chain = model_iv;
    n     = msg.size();
    idx   = 0;
    exp_pt.delete();
    exp_ct.delete();
    exp_last.delete();
    while (idx < n) begin
      nb  = (n - idx >= 8) ? 8 : n - idx;
      blk = 64'h0;
      for (int j = 0; j < 8; j++)
        blk = (blk << 8) | ((j < nb) ? 64'(msg[idx + j]) : 64'(8 - nb));
      exp_pt.push_back(blk ^ chain);
      chain = tea_enc(blk ^ chain);
      exp_ct.push_back(chain);
      idx += nb;
      exp_last.push_back(idx == n);
    end
  endfunction

  task automatic drive_byte(input logic [7:0] b, input logic l, input logic ivl,
                            input logic [63:0] ivv);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    iv_load  = ivl;
    iv       = ivv;
    wait_for(0, 100, "in_ready_timeout");
    @(posedge clk);
  endtask

  task automatic run_msg(input logic load_iv, input logic [63:0] new_iv, input int hold,
                         input logic poke);
    int idx, nb;
    logic        ivl;
    logic [63:0] ivv;
    if (load_iv) model_iv = new_iv;
    build_model();
    idx = 0;
    for (int b = 0; b < exp_pt.size(); b++) begin
      nb = (msg.size() - idx >= 8) ? 8 : msg.size() - idx;
      for (int j = 0; j < nb; j++) begin
        ivl = 1'b0;
        ivv = {$urandom, $urandom};
        if (load_iv && b == 0 && j == 0) begin
          ivl = 1'b1;
          ivv = new_iv;
        end else if (poke && j == 3) begin
          ivl = 1'b1;
        end
        drive_byte(msg[idx + j], (idx + j == msg.size() - 1), ivl, ivv);
      end
      idx += nb;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      iv_load  = 1'b0;
      exp_starts++;
      if (b == 0) first_pt = core_plaintext;
      check("core_start", {63'h0, core_start}, 64'h1);
      check("core_plaintext", core_plaintext, exp_pt[b]);
      check("in_ready_start", {63'h0, in_ready}, 64'h0);
      check("busy_start", {63'h0, busy}, 64'h1);
      @(negedge clk);
      check("start_one_cycle", {63'h0, core_start}, 64'h0);
      if (poke) begin
        iv_load = 1'b1;
        iv      = {$urandom, $urandom};
        @(negedge clk);
        iv_load = 1'b0;
      end
      wait_for(1, 200, "out_valid_timeout");
      check("out_data", out_data, exp_ct[b]);
      check("out_last", {63'h0, out_last}, {63'h0, exp_last[b]});
      check("start_count", 64'(n_starts), 64'(exp_starts));
      check("in_ready_out", {63'h0, in_ready}, 64'h0);
      repeat (hold) begin
        @(negedge clk);
        check("hold_out_data", out_data, exp_ct[b]);
        check("hold_out_valid", {63'h0, out_valid}, 64'h1);
        check("hold_in_ready", {63'h0, in_ready}, 64'h0);
        check("hold_start_count", 64'(n_starts), 64'(exp_starts));
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_after_hs", {63'h0, out_valid}, 64'h0);
      check("in_ready_after_hs", {63'h0, in_ready}, 64'h1);
    end
    check("busy_idle", {63'h0, busy}, 64'h0);
  endtask

  function automatic void random_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
  endfunction

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'h0, in_ready}, 64'h1);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_core_start", {63'h0, core_start}, 64'h0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_plaintext", core_plaintext, 64'h0);
    check("rst_out_last", {63'h0, out_last}, 64'h0);
    rst = 1'b0;

    // Full block, last on 8th byte: no pad block
    msg.delete();
    for (int i = 1; i <= 8; i++) msg.push_back(8'(i));
    run_msg(1'b1, 64'h0, 0, 1'b0);
    check("pt_01_08", first_pt, 64'h0102030405060708);

    // Short message padded with 05
    msg.delete();
    msg.push_back(8'hAA);
    msg.push_back(8'hBB);
    msg.push_back(8'hCC);
    run_msg(1'b1, 64'h0, 0, 1'b0);
    check("pt_aabbcc", first_pt, 64'hAABBCC0505050505);

    // Two zero blocks with all-ones IV: chaining
    msg.delete();
    for (int i = 0; i < 16; i++) msg.push_back(8'h00);
    run_msg(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    check("pt_iv_ones", first_pt, 64'hFFFF_FFFF_FFFF_FFFF);

    // Backpressure for 10 cycles, chain from the stored all-ones IV
    random_msg(5);
    run_msg(1'b0, 64'h0, 10, 1'b0);

    // IV strobes mid-fill and during WAIT must be ignored
    random_msg(12);
    run_msg(1'b1, {$urandom, $urandom}, 2, 1'b1);

    // Random messages
    for (int m = 0; m < 6; m++) begin
      random_msg($urandom_range(1, 20));
      run_msg(1'($urandom), {$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom));
    end

    // Reset while waiting on the core
    random_msg(8);
    for (int j = 0; j < 8; j++) drive_byte(msg[j], (j == 7), 1'b0, 64'h0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_starts++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("wrst_in_ready", {63'h0, in_ready}, 64'h1);
    check("wrst_busy", {63'h0, busy}, 64'h0);
    check("wrst_out_valid", {63'h0, out_valid}, 64'h0);
    check("wrst_core_start", {63'h0, core_start}, 64'h0);
    check("wrst_out_data", out_data, 64'h0);
    check("wrst_plaintext", core_plaintext, 64'h0);
    check("wrst_out_last", {63'h0, out_last}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    model_iv = 64'h0;

    // Recovery after reset: chain and stored IV are zero
    random_msg(3);
    run_msg(1'b0, 64'h0, 1, 1'b0);
    check("final_start_count", 64'(n_starts), 64'(exp_starts));

    summary_and_finish();
  end

endmodule

// File: doc/tea_cbc_packer.md
TEA_CBC_PACKER -- requirements
Module: tea_cbc_packer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk (rising edge), rst.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  upstream byte valid.
REQ-005 in_ready  output  1  byte accepted when in_valid && in_ready at a rising edge.
REQ-006 in_data  input  8  message byte.
REQ-007 in_last  input  1  marks the final byte of a message; qualified by in_valid.
REQ-008 iv_load  input  1  load iv into the chain register; single-cycle strobe.
REQ-009 iv  input  64  CBC initialisation vector.
REQ-010 core_start  output  1  single-cycle start pulse to the TEA encryption core.
REQ-011 core_plaintext  output  64  block to encrypt; held stable from the core_start cycle until core_done.
REQ-012 core_done  input  1  core completion flag; sticky high until the core accepts the next start.
REQ-013 core_ciphertext  input  64  core result; valid while core_done=1.
REQ-014 out_valid  output  1  ciphertext block available.
REQ-015 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-016 out_data  output  64  ciphertext block.
REQ-017 out_last  output  1  out_data is the final block of the message.
REQ-018 busy  output  1  high in every state except FILL with zero bytes buffered.

Function
REQ-019 States SHALL be FILL, START, WAIT, OUT; reset state FILL.
REQ-020 in_ready SHALL be 1 only in FILL; in all other states it SHALL be 0.
REQ-021 In FILL, each accepted byte SHALL be placed MSB-first (first byte -> bits 63:56); byte counter 0..7.
REQ-022 When the 8th byte is accepted, or when in_last is accepted, the FSM SHALL move to START on the next edge.
REQ-023 On in_last with k<8 bytes filled, the remaining 8-k bytes SHALL be padded with the value (8-k); if in_last completes 8 bytes, no pad block is generated.
REQ-024 core_plaintext SHALL equal the assembled block XOR the chain register, registered on entry to START.
REQ-025 START SHALL assert core_start for exactly one cycle and go to WAIT.
REQ-026 WAIT SHALL ignore core_done in its first cycle (stale sticky flag); thereafter, on core_done=1, it SHALL capture core_ciphertext into out_data and the chain register and go to OUT.
REQ-027 OUT SHALL hold out_valid=1 with out_data/out_last stable until out_ready=1; on handshake it SHALL return to FILL with counter 0.
REQ-028 out_last SHALL be 1 iff the block contained the in_last byte; after its handshake the chain register SHALL reload from the last value loaded via iv_load.
REQ-029 iv_load SHALL take effect only in FILL with counter 0; elsewhere it SHALL be ignored (no queuing).
REQ-030 iv_load and in_valid in the same cycle in FILL, counter 0: iv SHALL load first and the byte SHALL be accepted.
REQ-031 Throughput: one block per (fill cycles + 1 START + core latency + 1 + OUT wait) cycles; no overlap of blocks.

Reset
REQ-032 rst SHALL force state FILL, counter 0, chain register and stored IV to 0, core_start=0, out_valid=0, out_last=0, out_data=0, core_plaintext=0, busy=0.
REQ-033 rst mid-block or mid-WAIT SHALL discard buffered data; the bench SHALL reset the core concurrently.

Structure
REQ-034 Package tea_pkg SHALL hold BLOCK_W=64, BYTES_PER_BLOCK=8 and the FSM state enum.
REQ-035 Byte assembly and padding SHALL be a sub-module tea_byte_packer (shift register, counter, pad logic); the top holds FSM, chain register and output register.

Verification (bench uses a behavioural TEA core model with configurable latency, default 32)
REQ-036 iv=0, bytes 01..08 with last on 08 -> core_plaintext=0x0102030405060708, one core_start pulse, out_last=1.
REQ-037 iv=0, bytes AA BB CC with last -> core_plaintext=0xAABBCC0505050505.
REQ-038 iv=0xFFFFFFFFFFFFFFFF, 16 bytes of 00 -> block1 plaintext=0xFFFF_FFFF_FFFF_FFFF; block2 plaintext=block1 ciphertext.
REQ-039 out_ready held low 10 cycles in OUT -> out_data stable, in_ready=0, no core_start.
REQ-040 iv_load during WAIT -> ignored; rst asserted in WAIT -> all outputs at reset values next cycle.
